pmp_csr_regs: RTL

Machine-mode register file and write-side controller for PMP configuration: holds pmpcfg/pmpaddr state, applies RISC-V WARL and lock rules on CSR writes, serves CSR reads, and drives the configuration bus consumed by the PMP checkers (`conf_i`, `conf_addr_i`). It sits between the CSR file's PMP access port and every PMP checker instance. It signals checker-side caches on each effective change.

---
 rtl/pmp_csr_regs.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pmp_csr_regs.sv
// pmp_csr_regs: machine-mode PMP configuration register file.
//
// Holds the pmpcfg/pmpaddr state for up to 16 PMP entries. CSR writes are filtered
// through the WARL and lock rules, CSR reads are served from the stored state, and
// the result drives the configuration bus seen by every PMP checker.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   priv_lvl_i         requester privilege, sampled on accept
//   req_valid_i/ready  CSR request handshake (accept when both high)
//   req_we_i           1 = write, 0 = read
//   req_addr_i         CSR address (0x3A0/0x3A2 pmpcfg, 0x3B0..0x3BF pmpaddr)
//   req_wdata_i        write data
//   rsp_valid_o        one-cycle response pulse
//   rsp_rdata_o        read data (0 for writes and errors)
//   rsp_err_o          illegal access, qualified by rsp_valid_o
//   conf_o             per-entry pmpcfg to the checkers
//   conf_addr_o        per-entry pmpaddr to the checkers
//   flush_o            one-cycle pulse when any stored bit changed

package riscv;
    typedef enum logic [1:0] {
        PRIV_LVL_U  = 2'b00,
        PRIV_LVL_S  = 2'b01,
        PRIV_LVL_HS = 2'b10,
        PRIV_LVL_M  = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;
endpackage

module pmp_csr_regs #(
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned XLEN       = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  riscv::priv_lvl_t          priv_lvl_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [11:0]               req_addr_i,
    input  logic [XLEN-1:0]           req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [XLEN-1:0]           rsp_rdata_o,
    output logic                      rsp_err_o,
    output riscv::pmpcfg_t [15:0]     conf_o,
    output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
    output logic                      flush_o
);

    localparam logic [11:0] CsrPmpCfg0 = 12'h3A0;
    localparam logic [11:0] CsrPmpCfg2 = 12'h3A2;
    localparam logic [7:0]  CsrPmpAddr = 8'h3B;

    typedef enum logic [1:0] {StIdle, StCommit, StResp} state_e;

    state_e                      state_q;
    logic [11:0]                 req_addr_q;
    logic [XLEN-1:0]             req_wdata_q;
    riscv::pmpcfg_t [15:0]       pmpcfg_q, pmpcfg_d;
    logic [15:0][PMP_LEN-1:0]    pmpaddr_q, pmpaddr_d;
    logic                        rsp_valid_q, rsp_err_q, flush_q;
    logic [XLEN-1:0]             rsp_rdata_q;

    logic                        req_is_cfg, req_is_addr, req_legal;
    logic [XLEN-1:0]             rd_data;
    logic [15:0]                 tor_lock;
    logic [3:0]                  cfg_idx;
    logic [7:0]                  cfg_byte;
    logic [3:0]                  addr_idx;
    logic                        commit_change;

    // Ready is gated by reset so nothing can be accepted while rst_i is high.
    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign flush_o     = flush_q;

    // Unimplemented entries are never written, but tie them off explicitly as well.
    for (genvar i = 0; i < 16; i++) begin : g_out
        assign conf_o[i]      = (i < NR_ENTRIES) ? pmpcfg_q[i] : '0;
        assign conf_addr_o[i] = (i < NR_ENTRIES) ? pmpaddr_q[i] : '0;
    end

    // Request decode and read mux, evaluated on the incoming request in IDLE.
    always_comb begin
        req_is_cfg  = (req_addr_i == CsrPmpCfg0) || (req_addr_i == CsrPmpCfg2);
        req_is_addr = (req_addr_i[11:4] == CsrPmpAddr);
        req_legal   = (priv_lvl_i == riscv::PRIV_LVL_M) && (req_is_cfg || req_is_addr);
        rd_data     = '0;
        if (req_is_cfg) begin
            for (int unsigned b = 0; b < 8; b++) begin
                rd_data[8*b +: 8] = conf_o[{req_addr_i[1], b[2:0]}];
            end
        end else if (req_is_addr) begin
            rd_data[PMP_LEN-1:0] = conf_addr_o[req_addr_i[3:0]];
        end
    end

    // tor_lock[i]: pmpaddr[i] is frozen because entry i+1 is a locked TOR region
    // that uses it as its lower bound.
    always_comb begin
        tor_lock = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            tor_lock[4'(i)] = (i + 1 < NR_ENTRIES) && pmpcfg_q[4'(i + 1)].locked &&
                              (pmpcfg_q[4'(i + 1)].addr_mode == riscv::TOR);
        end
    end

    // Filtered next state for the latched write. All lock checks look at the
    // pre-write state, so bytes of one write never influence each other.
    always_comb begin
        pmpcfg_d  = pmpcfg_q;
        pmpaddr_d = pmpaddr_q;
        cfg_idx   = '0;
        cfg_byte  = '0;
        addr_idx  = req_addr_q[3:0];
        if (req_addr_q[11:4] != CsrPmpAddr) begin
            for (int unsigned b = 0; b < 8; b++) begin
                cfg_idx  = {req_addr_q[1], b[2:0]};
                cfg_byte = req_wdata_q[8*b +: 8];
                // R=0/W=1 is reserved: the whole byte keeps its old value.
                if ((32'(cfg_idx) < NR_ENTRIES) && !pmpcfg_q[cfg_idx].locked &&
                    !(!cfg_byte[0] && cfg_byte[1])) begin
                    pmpcfg_d[cfg_idx] = riscv::pmpcfg_t'({cfg_byte[7], 2'b00, cfg_byte[4:0]});
                end
            end
        end else begin
            if ((32'(addr_idx) < NR_ENTRIES) && !pmpcfg_q[addr_idx].locked &&
                !tor_lock[addr_idx]) begin
                pmpaddr_d[addr_idx] = req_wdata_q[PMP_LEN-1:0];
            end
        end
        commit_change = (pmpcfg_d != pmpcfg_q) || (pmpaddr_d != pmpaddr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            pmpcfg_q    <= '0;
            pmpaddr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    flush_q     <= 1'b0;
                    if (req_valid_i) begin
                        if (req_we_i && req_legal) begin
                            req_addr_q  <= req_addr_i;
                            req_wdata_q <= req_wdata_i;
                            state_q     <= StCommit;
                        end else begin
                            // Reads and all illegal accesses answer straight away.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= !req_legal;
                            rsp_rdata_q <= req_legal ? rd_data : '0;
                            state_q     <= StResp;
                        end
                    end
                end
                StCommit: begin
                    pmpcfg_q    <= pmpcfg_d;
                    pmpaddr_q   <= pmpaddr_d;
                    flush_q     <= commit_change;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    flush_q     <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
